// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: LSB-first deserialiser with parity and 1/2 stop-bit checks; RX_ERR_CNT_EN adds saturating error counters.
// Latency: frame_valid pulses for one clk after the edge that accepts the last stop strobe.
// Backpressure: none; the sampler paces the frame via bit_strobe, and frame_start restarts at any time.
module uart_rx_frame_check #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EN,
    input  logic [3:0]           cfg_width,
    input  logic                 Par_chk_en,
    input  logic [1:0]           Parity_Type,
    input  logic                 cfg_stop2,
    input  logic                 frame_start,
    input  logic                 bit_strobe,
    input  logic                 sampled_bit,
    output logic [MAX_WIDTH-1:0] P_Data,
    output logic                 frame_valid,
    output logic                 par_error,
    output logic                 stop_error,
    output logic                 busy,
    output logic [CNT_W-1:0]     par_err_cnt,
    output logic [CNT_W-1:0]     stop_err_cnt,
    input  logic                 cnt_clr
);
    localparam logic [3:0] MAXW = 4'(MAX_WIDTH);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

    state_t               state, state_nxt;
    logic [MAX_WIDTH-1:0] shift_reg, shift_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [3:0]           width_lat, width_nxt, width_clamped;
    logic [1:0]           ptype_lat, ptype_nxt;
    logic                 par_en_lat, par_en_nxt;
    logic                 stop2_lat, stop2_nxt;
    logic                 stop_idx, stop_idx_nxt;
    logic                 par_acc, par_acc_nxt;
    logic                 par_pend, par_pend_nxt;
    logic                 stop_pend, stop_pend_nxt;
    logic                 par_exp;
    logic                 load_out;

    always_comb begin
        width_clamped = cfg_width;
        if (cfg_width < 4'd5)
            width_clamped = 4'd5;
        else if (cfg_width > MAXW)
            width_clamped = MAXW;
    end

    always_comb begin
        unique case (ptype_lat)
            2'b00:   par_exp = par_acc;
            2'b01:   par_exp = ~par_acc;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        bit_cnt_nxt   = bit_cnt;
        width_nxt     = width_lat;
        ptype_nxt     = ptype_lat;
        par_en_nxt    = par_en_lat;
        stop2_nxt     = stop2_lat;
        stop_idx_nxt  = stop_idx;
        par_acc_nxt   = par_acc;
        par_pend_nxt  = par_pend;
        stop_pend_nxt = stop_pend;
        load_out      = 1'b0;
        if (!EN) begin
            state_nxt = IDLE;
        end else if (frame_start) begin
            // Restart wins over everything, including a same-cycle strobe.
            state_nxt     = DATA;
            width_nxt     = width_clamped;
            ptype_nxt     = Parity_Type;
            par_en_nxt    = Par_chk_en;
            stop2_nxt     = cfg_stop2;
            shift_nxt     = '0;
            bit_cnt_nxt   = '0;
            stop_idx_nxt  = 1'b0;
            par_acc_nxt   = 1'b0;
            par_pend_nxt  = 1'b0;
            stop_pend_nxt = 1'b0;
        end else begin
            unique case (state)
                DATA: if (bit_strobe) begin
                    for (int i = 0; i < MAX_WIDTH; i++)
                        if (bit_cnt == 4'(i))
                            shift_nxt[i] = sampled_bit;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    par_acc_nxt = par_acc ^ sampled_bit;
                    if (bit_cnt == width_lat - 4'd1)
                        state_nxt = par_en_lat ? PARITY : STOP;
                end
                PARITY: if (bit_strobe) begin
                    par_pend_nxt = par_exp ^ sampled_bit;
                    state_nxt    = STOP;
                end
                STOP: if (bit_strobe) begin
                    stop_pend_nxt = stop_pend | ~sampled_bit;
                    if (stop2_lat && !stop_idx) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            width_lat  <= 4'd5;
            ptype_lat  <= 2'b00;
            par_en_lat <= 1'b0;
            stop2_lat  <= 1'b0;
            stop_idx   <= 1'b0;
            par_acc    <= 1'b0;
            par_pend   <= 1'b0;
            stop_pend  <= 1'b0;
            P_Data     <= '0;
            par_error  <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            width_lat  <= width_nxt;
            ptype_lat  <= ptype_nxt;
            par_en_lat <= par_en_nxt;
            stop2_lat  <= stop2_nxt;
            stop_idx   <= stop_idx_nxt;
            par_acc    <= par_acc_nxt;
            par_pend   <= par_pend_nxt;
            stop_pend  <= stop_pend_nxt;
            // Results are registered on entry to DONE so they are stable during the pulse.
            if (load_out) begin
                P_Data     <= shift_reg;
                par_error  <= par_pend_nxt;
                stop_error <= stop_pend_nxt;
            end
        end
    end

    assign frame_valid = EN && (state == DONE);
    assign busy        = EN && ((state == DATA) || (state == PARITY) || (state == STOP));

`ifdef RX_ERR_CNT_EN
    logic [CNT_W-1:0] par_cnt_r, stop_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_cnt_r  <= '0;
            stop_cnt_r <= '0;
        end else if (cnt_clr) begin
            par_cnt_r  <= '0;
            stop_cnt_r <= '0;
        end else if (frame_valid) begin
            if (par_error && !(&par_cnt_r))
                par_cnt_r <= par_cnt_r + 1'b1;
            if (stop_error && !(&stop_cnt_r))
                stop_cnt_r <= stop_cnt_r + 1'b1;
        end
    end

    assign par_err_cnt  = par_cnt_r;
    assign stop_err_cnt = stop_cnt_r;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign par_err_cnt    = '0;
    assign stop_err_cnt   = '0;
`endif
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: frames driven bit by bit, expected results queued at drive time.
module tb_uart_rx_frame_check;
    localparam int MW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          EN;
    logic [3:0]    cfg_width;
    logic          Par_chk_en;
    logic [1:0]    Parity_Type;
    logic          cfg_stop2;
    logic          frame_start;
    logic          bit_strobe;
    logic          sampled_bit;
    logic [MW-1:0] P_Data;
    logic          frame_valid;
    logic          par_error;
    logic          stop_error;
    logic          busy;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stop_err_cnt;
    logic          cnt_clr;

    always #5 clk = ~clk;

    uart_rx_frame_check #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .cfg_width(cfg_width),
        .Par_chk_en(Par_chk_en), .Parity_Type(Parity_Type), .cfg_stop2(cfg_stop2),
        .frame_start(frame_start), .bit_strobe(bit_strobe), .sampled_bit(sampled_bit),
        .P_Data(P_Data), .frame_valid(frame_valid), .par_error(par_error),
        .stop_error(stop_error), .busy(busy), .par_err_cnt(par_err_cnt),
        .stop_err_cnt(stop_err_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;

    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt++;
            obs_q.push_back({P_Data, par_error, stop_error});
        end
    end

    function automatic int clamp_w(input int w);
        return (w < 5) ? 5 : ((w > MW) ? MW : w);
    endfunction

    function automatic res_t model(input int w, input logic [7:0] d, input logic pen,
                                   input logic [1:0] pt, input logic s2, input logic pbit,
                                   input logic s0, input logic s1);
        res_t r;
        logic [7:0] m;
        logic [7:0] dm;
        logic e;
        m  = 8'hFF >> (8 - clamp_w(w));
        dm = d & m;
        case (pt)
            2'b00:   e = ^dm;
            2'b01:   e = ~^dm;
            2'b10:   e = 1'b1;
            default: e = 1'b0;
        endcase
        r.data = dm;
        r.perr = pen ? (e ^ pbit) : 1'b0;
        r.serr = ~s0 | (s2 & ~s1);
        return r;
    endfunction

    task automatic strobe(input logic b);
        @(negedge clk);
        bit_strobe  = 1'b1;
        sampled_bit = b;
        @(negedge clk);
        bit_strobe  = 1'b0;
        sampled_bit = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic start_frame(input int w, input logic pen, input logic [1:0] pt, input logic s2);
        @(negedge clk);
        cfg_width   = 4'(w);
        Par_chk_en  = pen;
        Parity_Type = pt;
        cfg_stop2   = s2;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Drives a whole frame; cnt_clr, if requested, lands exactly in the DONE cycle.
    task automatic send_frame(input int w, input logic [7:0] d, input logic pen,
                              input logic [1:0] pt, input logic s2, input logic pbit,
                              input logic s0, input logic s1, input logic clr);
        logic last;
        exp_q.push_back(model(w, d, pen, pt, s2, pbit, s0, s1));
        start_frame(w, pen, pt, s2);
        for (int i = 0; i < clamp_w(w); i++) strobe(d[i]);
        if (pen) strobe(pbit);
        if (s2) begin
            strobe(s0);
            last = s1;
        end else begin
            last = s0;
        end
        @(negedge clk);
        bit_strobe  = 1'b1;
        sampled_bit = last;
        @(negedge clk);
        bit_strobe  = 1'b0;
        cnt_clr     = clr;
        @(negedge clk);
        cnt_clr     = 1'b0;
    endtask

    task automatic get_frame(output res_t got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 20; i++) begin
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EN = 1'b1; cfg_width = 4'd8; Par_chk_en = 1'b0; Parity_Type = 2'b00;
        cfg_stop2 = 1'b0; frame_start = 1'b0; bit_strobe = 1'b0; sampled_bit = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (P_Data !== 8'h00 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: P_Data=%h valid=%b busy=%b, want 00/0/0", P_Data, frame_valid, busy);
        end
        checks++;
        if (par_error !== 1'b0 || stop_error !== 1'b0 || par_err_cnt !== '0 || stop_err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_flags: perr=%b serr=%b pcnt=%0d scnt=%0d, want all 0",
                     par_error, stop_error, par_err_cnt, stop_err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b, want 0/0", busy, frame_valid);
        end
    endtask

    task automatic test_basic();
        res_t got, e;
        bit ok;
        send_frame(8, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL basic_even: got %h (seen=%0d) want %h", got, ok, e);
        end
    endtask

    task automatic test_odd();
        res_t got, e;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            send_frame(8, 8'h03, 1'b1, 2'b01, 1'b0, 1'(k), 1'b1, 1'b1, 1'b0);
            get_frame(got, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL odd_parity_%0d: got %h (seen=%0d) want %h", k, got, ok, e);
            end
        end
    endtask

    task automatic test_stop2();
        res_t got, e;
        bit ok;
        send_frame(5, 8'h1F, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL stop2_err: got %h (seen=%0d) want %h", got, ok, e);
        end
        send_frame(6, 8'h2A, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL stop2_first: got %h (seen=%0d) want %h", got, ok, e);
        end
    endtask

    task automatic test_mark_space();
        res_t got, e;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            send_frame(7, 8'h00, 1'b1, (k == 0) ? 2'b11 : 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            get_frame(got, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL mark_space_%0d: got %h (seen=%0d) want %h", k, got, ok, e);
            end
        end
    endtask

    task automatic test_abort();
        res_t got, e;
        bit ok;
        int v0;
        v0 = valid_cnt;
        start_frame(8, 1'b0, 2'b00, 1'b0);
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid: busy=%b want 1", busy);
        end
        send_frame(8, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL restart_data: got %h (seen=%0d) want %h", got, ok, e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cnt - v0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_pulses: pulses=%0d busy=%b want 1/0", valid_cnt - v0, busy);
        end
    endtask

    task automatic test_clamp();
        res_t got, e;
        bit ok;
        int v0;
        send_frame(15, 8'hC3, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL clamp_high: got %h (seen=%0d) want %h", got, ok, e);
        end
        send_frame(2, 8'hF5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL clamp_low: got %h (seen=%0d) want %h", got, ok, e);
        end
        v0 = valid_cnt;
        for (int i = 0; i < 12; i++) strobe(1'($urandom));
        checks++;
        if (valid_cnt !== v0 || P_Data !== e.data || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes: pulses=%0d P_Data=%h busy=%b want 0/%h/0",
                     valid_cnt - v0, P_Data, busy, e.data);
        end
    endtask

    task automatic test_enable();
        logic [7:0] held;
        int v0;
        held = P_Data;
        v0   = valid_cnt;
        start_frame(8, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        @(negedge clk);
        EN = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_low: busy=%b valid=%b want 0/0", busy, frame_valid);
        end
        @(negedge clk);
        EN = 1'b1;
        for (int i = 0; i < 8; i++) strobe(1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cnt !== v0 || P_Data !== held) begin
            errors++;
            $display("FAIL en_abort: pulses=%0d P_Data=%h want 0/%h", valid_cnt - v0, P_Data, held);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = valid_cnt;
        start_frame(8, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) strobe(1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (P_Data !== 8'h00 || busy !== 1'b0 || frame_valid !== 1'b0 ||
            par_error !== 1'b0 || stop_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: P_Data=%h busy=%b valid=%b perr=%b serr=%b want all 0",
                     P_Data, busy, frame_valid, par_error, stop_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) strobe(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL reset_mid_pulse: pulses=%0d want 0", valid_cnt - v0);
        end
    endtask

    task automatic test_counters();
        res_t got, e;
        bit ok;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(8, 8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            get_frame(got, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL cnt_frame_%0d: got %h (seen=%0d) want %h", k, got, ok, e);
            end
        end
`ifdef RX_ERR_CNT_EN
        checks++;
        if (par_err_cnt !== 2'd3 || stop_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_saturate: par=%0d stop=%0d want 3/0", par_err_cnt, stop_err_cnt);
        end
`else
        checks++;
        if (par_err_cnt !== 2'd0 || stop_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_tied: par=%0d stop=%0d want 0/0", par_err_cnt, stop_err_cnt);
        end
`endif
        send_frame(8, 8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        get_frame(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e || par_err_cnt !== 2'd0 || stop_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clr_wins: got %h (seen=%0d) want %h, par=%0d stop=%0d want 0/0",
                     got, ok, e, par_err_cnt, stop_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_stop2();
        test_mark_space();
        test_abort();
        test_clamp();
        test_enable();
        test_reset_mid();
        test_counters();
        checks++;
        if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: expected left=%0d observed left=%0d want 0/0",
                     exp_q.size(), obs_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
